// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC transaction scheduler.
// Covers scheduler states, transaction kinds and the RTC register map.
package rtc_pkg;

  typedef enum logic [2:0] {
    INIT_ISSUE,
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    COMPLETE
  } state_t;

  typedef enum logic [1:0] {
    K_INIT,
    K_USER,
    K_SWEEP
  } kind_t;

  localparam logic [7:0] ADDR_CMD_INIT = 8'h02;
  localparam logic [7:0] ADDR_SEG      = 8'h21;
  localparam logic [7:0] ADDR_MIN      = 8'h22;
  localparam logic [7:0] ADDR_HORA     = 8'h23;
  localparam logic [7:0] ADDR_DIA      = 8'h24;
  localparam logic [7:0] ADDR_MES      = 8'h25;
  localparam logic [7:0] ADDR_ANIO     = 8'h26;

  localparam logic [7:0] INIT_DATA_0 = 8'h10;
  localparam logic [7:0] INIT_DATA_1 = 8'h00;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  function automatic logic [7:0] sweep_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    return ADDR_SEG;
      3'd1:    return ADDR_MIN;
      3'd2:    return ADDR_HORA;
      3'd3:    return ADDR_DIA;
      3'd4:    return ADDR_MES;
      3'd5:    return ADDR_ANIO;
      default: return ADDR_SEG;
    endcase
  endfunction

endpackage

// File: rtl/rtc_refresh_timer.sv
// Free-running refresh counter; emits a one-cycle tick every REFRESH_CYCLES
// enabled cycles. Needs 2**CNT_W > REFRESH_CYCLES.
module rtc_refresh_timer #(
  parameter int REFRESH_CYCLES = 10_000_000,
  parameter int CNT_W          = 24
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_end;

  assign at_end = (cnt_q == CNT_W'(REFRESH_CYCLES - 1));

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (en_i) begin
      if (at_end) begin
        cnt_d  = '0;
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rtc_scheduler.sv
// Schedules init writes, periodic time/date sweeps and user writes onto the
// RTC bus engine, one transaction at a time.
//
// state      | meaning
// INIT_ISSUE | first cycle out of reset, sets up init write 0
// IDLE       | transaction boundary, picks init / user write / sweep read
// ISSUE      | flag_in pulse, transaction parameters held
// WAIT_START | waiting for engine busy, bounded by START_TIMEOUT
// WAIT_DONE  | engine busy, read data captured on tomar_dato
// COMPLETE   | bookkeeping and ack/done pulses
module rtc_scheduler
  import rtc_pkg::*;
#(
  parameter int REFRESH_CYCLES = 10_000_000,
  parameter int START_TIMEOUT  = 8,
  parameter int CNT_W          = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       flag_in,
  output logic       lee_escribe_m,
  output logic [7:0] add,
  output logic [7:0] datos,
  input  logic       flag_work_s,
  input  logic       tomar_dato,
  input  logic [7:0] data,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic       sweep_done,
  output logic       init_done,
  output logic       busy,
  output logic       error
);

  localparam int              TO_W    = $clog2(START_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TIMEOUT - 1);

  state_t          state_q;
  kind_t           kind_q;
  logic [2:0]      idx_q;
  logic            init_idx_q;
  logic            sweep_q;
  logic            fw_q;
  logic [TO_W-1:0] to_cnt_q;
  logic [7:0]      shadow_q [6];
  logic            wr_ack_q, flag_in_q, op_q, sweep_done_q;
  logic            init_done_q, busy_q, error_q;
  logic [7:0]      add_q, datos_q;
  logic            tick;

  rtc_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk_i (clk),
    .rst_ni(reset),
    .en_i  (init_done_q),
    .tick_o(tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= INIT_ISSUE;
      kind_q       <= K_INIT;
      idx_q        <= '0;
      init_idx_q   <= 1'b0;
      sweep_q      <= 1'b0;
      fw_q         <= 1'b0;
      to_cnt_q     <= '0;
      for (int i = 0; i < 6; i++) shadow_q[i] <= '0;
      wr_ack_q     <= 1'b0;
      flag_in_q    <= 1'b0;
      op_q         <= OP_READ;
      add_q        <= '0;
      datos_q      <= '0;
      sweep_done_q <= 1'b0;
      init_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      flag_in_q    <= 1'b0;
      wr_ack_q     <= 1'b0;
      sweep_done_q <= 1'b0;
      fw_q         <= flag_work_s;
      // A tick while a sweep is pending or running is dropped, not queued.
      if (tick && !sweep_q) sweep_q <= 1'b1;

      case (state_q)
        INIT_ISSUE, IDLE: begin
          if (!init_done_q) begin
            kind_q    <= K_INIT;
            op_q      <= OP_WRITE;
            add_q     <= ADDR_CMD_INIT;
            datos_q   <= init_idx_q ? INIT_DATA_1 : INIT_DATA_0;
            flag_in_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ISSUE;
          end else if (wr_req) begin
            kind_q    <= K_USER;
            op_q      <= OP_WRITE;
            add_q     <= wr_addr;
            datos_q   <= wr_data;
            flag_in_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ISSUE;
          end else if (sweep_q) begin
            kind_q    <= K_SWEEP;
            op_q      <= OP_READ;
            add_q     <= sweep_addr(idx_q);
            datos_q   <= '0;
            flag_in_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          to_cnt_q <= '0;
          state_q  <= WAIT_START;
        end
        WAIT_START: begin
          if (flag_work_s) begin
            state_q <= WAIT_DONE;
          end else if (to_cnt_q == TO_LAST) begin
            // Drop the transaction; a user/init write is retried from IDLE.
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
            if (kind_q == K_SWEEP) begin
              sweep_q <= 1'b0;
              idx_q   <= '0;
            end
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (tomar_dato && kind_q == K_SWEEP) shadow_q[idx_q] <= data;
          if (fw_q && !flag_work_s) begin
            busy_q       <= 1'b0;
            wr_ack_q     <= (kind_q == K_USER);
            sweep_done_q <= (kind_q == K_SWEEP) && (idx_q == 3'd5);
            state_q      <= COMPLETE;
          end
        end
        COMPLETE: begin
          state_q <= IDLE;
          case (kind_q)
            K_INIT: begin
              if (init_idx_q) init_done_q <= 1'b1;
              else            init_idx_q  <= 1'b1;
            end
            K_SWEEP: begin
              if (idx_q == 3'd5) begin
                idx_q   <= '0;
                sweep_q <= 1'b0;
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end
            default: ;
          endcase
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_ack        = wr_ack_q;
  assign flag_in       = flag_in_q;
  assign lee_escribe_m = op_q;
  assign add           = add_q;
  assign datos         = datos_q;
  assign seg           = shadow_q[0];
  assign min           = shadow_q[1];
  assign hora          = shadow_q[2];
  assign dia           = shadow_q[3];
  assign mes           = shadow_q[4];
  assign anio          = shadow_q[5];
  assign sweep_done    = sweep_done_q;
  assign init_done     = init_done_q;
  assign busy          = busy_q;
  assign error         = error_q;

endmodule

// File: tb/tb_rtc_scheduler.sv
// Bench for rtc_scheduler: behavioural RTC engine plus expected transaction
// lists and shadow values derived from the scheduling rules.
`timescale 1ns/1ps
module tb_rtc_scheduler;

  localparam int RC = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_req = 1'b0;
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ack, flag_in, lee_escribe_m;
  logic [7:0] add, datos;
  logic       flag_work_s, tomar_dato;
  logic [7:0] data;
  logic [7:0] seg, min, hora, dia, mes, anio;
  logic       sweep_done, init_done, busy, error;

  typedef struct {
    logic       op;
    logic [7:0] a;
    logic [7:0] d;
    int         c;
  } txn_t;

  txn_t       log_q[$];
  txn_t       exp_q[$];
  logic [7:0] mem [256];
  logic [7:0] exp_sh [6];
  logic [7:0] plan [6] = '{8'h45, 8'h30, 8'h12, 8'h07, 8'h04, 8'h17};
  logic       mute = 1'b0;
  int         cyc = 0, checks = 0, errors = 0, n_sd = 0, n_ack = 0;

  rtc_scheduler #(.REFRESH_CYCLES(RC), .START_TIMEOUT(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .flag_in(flag_in), .lee_escribe_m(lee_escribe_m), .add(add),
    .datos(datos), .flag_work_s(flag_work_s), .tomar_dato(tomar_dato), .data(data),
    .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
    .sweep_done(sweep_done), .init_done(init_done), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (sweep_done === 1'b1) n_sd <= n_sd + 1;
    if (wr_ack === 1'b1) n_ack <= n_ack + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural engine: busy 2 cycles after flag_in for 30 cycles, read data
  // strobed mid-transaction, writes update the register image.
  initial begin
    txn_t t;
    flag_work_s = 1'b0;
    tomar_dato  = 1'b0;
    data        = 8'h00;
    forever begin
      step();
      if (reset && flag_in === 1'b1) begin
        t.op = lee_escribe_m; t.a = add; t.d = datos; t.c = cyc;
        log_q.push_back(t);
        if (!mute) begin
          step();
          step();
          flag_work_s = 1'b1;
          for (int i = 0; i < 30 && reset; i++) begin
            tomar_dato = (i == 20) && !t.op;
            data       = tomar_dato ? mem[t.a] : 8'h00;
            step();
          end
          if (reset) begin
            check_eq("hold_op", lee_escribe_m, t.op);
            check_eq("hold_addr", add, t.a);
            if (t.op) begin
              check_eq("hold_data", datos, t.d);
              mem[t.a] = t.d;
            end
          end
          flag_work_s = 1'b0;
          tomar_dato  = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void push_txn(input logic op, input logic [7:0] a, input logic [7:0] d);
    txn_t t;
    t.op = op; t.a = a; t.d = d; t.c = 0;
    exp_q.push_back(t);
  endfunction

  function automatic void push_sweep();
    for (int i = 0; i < 6; i++) push_txn(1'b0, 8'(33 + i), 8'h00);
  endfunction

  task automatic set_rtc(input logic rnd);
    for (int i = 0; i < 6; i++) begin
      exp_sh[i]   = rnd ? 8'($urandom) : plan[i];
      mem[33 + i] = exp_sh[i];
    end
  endtask

  task automatic check_seq(input string tag);
    check_eq({tag, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check_eq($sformatf("%s_op%0d", tag, i), log_q[i].op, exp_q[i].op);
      check_eq($sformatf("%s_addr%0d", tag, i), log_q[i].a, exp_q[i].a);
      if (exp_q[i].op) check_eq($sformatf("%s_data%0d", tag, i), log_q[i].d, exp_q[i].d);
    end
  endtask

  task automatic check_shadows(input string tag);
    check_eq({tag, "_seg"}, seg, exp_sh[0]);
    check_eq({tag, "_min"}, min, exp_sh[1]);
    check_eq({tag, "_hora"}, hora, exp_sh[2]);
    check_eq({tag, "_dia"}, dia, exp_sh[3]);
    check_eq({tag, "_mes"}, mes, exp_sh[4]);
    check_eq({tag, "_anio"}, anio, exp_sh[5]);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_flag_in"}, flag_in, 0);
    check_eq({tag, "_op"}, lee_escribe_m, 0);
    check_eq({tag, "_add"}, add, 0);
    check_eq({tag, "_datos"}, datos, 0);
    check_eq({tag, "_init_done"}, init_done, 0);
    check_eq({tag, "_error"}, error, 0);
    check_eq({tag, "_wr_ack"}, wr_ack, 0);
    check_eq({tag, "_sweep_done"}, sweep_done, 0);
    check_eq({tag, "_shadows"}, {seg, min, hora, dia}, 0);
    check_eq({tag, "_shadows2"}, {mes, anio}, 0);
  endtask

  task automatic wait_sweep_done(input string tag, input int budget);
    int n = 0;
    while (sweep_done !== 1'b1 && n < budget) begin step(); n++; end
    check_eq({tag, "_sweep_done_seen"}, sweep_done, 1);
  endtask

  task automatic wait_ack(input string tag, input int budget);
    int n = 0;
    while (wr_ack !== 1'b1 && n < budget) begin step(); n++; end
    check_eq({tag, "_wr_ack_seen"}, wr_ack, 1);
  endtask

  task automatic wait_init(input string tag, input int budget);
    int n = 0;
    while (init_done !== 1'b1 && n < budget) begin step(); n++; end
    check_eq({tag, "_init_done"}, init_done, 1);
  endtask

  task automatic wait_log(input string tag, input int cnt, input int budget);
    int n = 0;
    while (log_q.size() < cnt && n < budget) begin step(); n++; end
    check_eq({tag, "_issued"}, log_q.size() >= cnt, 1);
  endtask

  initial begin
    int k0, cd, t0, c0, sd0, ack0, n;
    logic [7:0] wa, wd;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state
    repeat (3) step();
    check_all_zero("rst");
    set_rtc(1'b0);
    reset = 1'b1;

    // Init sequence
    wait_init("init", 500);
    k0 = cyc;
    exp_q.delete();
    push_txn(1'b1, 8'h02, 8'h10);
    push_txn(1'b1, 8'h02, 8'h00);
    check_seq("init");
    check_eq("init_busy", busy, 0);
    log_q.delete();

    // First sweep: plan values, timing of first refresh tick
    wait_sweep_done("sw1", 1000);
    exp_q.delete();
    push_sweep();
    check_seq("sw1");
    if (log_q.size() > 0) check_eq("sw1_period", log_q[0].c, k0 + RC + 1);
    check_shadows("sw1");
    step();
    check_eq("sw1_done_pulses", n_sd, 1);

    // User write inserted during the read of 8'h22
    log_q.delete();
    set_rtc(1'b1);
    sd0 = n_sd; ack0 = n_ack;
    wait_log("mid", 2, 1000);
    wr_addr = 8'h23; wr_data = 8'h09; wr_req = 1'b1;
    wait_ack("mid", 500);
    wr_req = 1'b0;
    exp_sh[2] = 8'h09;
    wait_sweep_done("mid", 1000);
    cd = cyc;
    exp_q.delete();
    push_txn(1'b0, 8'h21, 8'h00);
    push_txn(1'b0, 8'h22, 8'h00);
    push_txn(1'b1, 8'h23, 8'h09);
    for (int i = 2; i < 6; i++) push_txn(1'b0, 8'(33 + i), 8'h00);
    check_seq("mid");
    check_shadows("mid");

    // wr_req in the very cycle of a refresh tick
    t0 = k0 + RC - 1;
    while (t0 <= cd) t0 += RC;
    while (cyc < t0) step();
    check_eq("mid_done_pulses", n_sd - sd0, 1);
    check_eq("mid_acks", n_ack - ack0, 1);
    log_q.delete();
    set_rtc(1'b1);
    sd0 = n_sd; ack0 = n_ack;
    wa = 8'(8'h21 + $urandom_range(0, 5));
    wd = 8'($urandom);
    wr_addr = wa; wr_data = wd; wr_req = 1'b1;
    exp_sh[int'(wa) - 33] = wd;
    wait_ack("tick", 500);
    wr_req = 1'b0;
    wait_sweep_done("tick", 1000);
    exp_q.delete();
    push_txn(1'b1, wa, wd);
    push_sweep();
    check_seq("tick");
    if (log_q.size() > 0) check_eq("tick_write_first", log_q[0].c, t0 + 1);
    check_shadows("tick");

    // Start timeout aborts the sweep; next tick restarts at index 0
    step();
    check_eq("tick_done_pulses", n_sd - sd0, 1);
    check_eq("tick_acks", n_ack - ack0, 1);
    log_q.delete();
    set_rtc(1'b1);
    sd0 = n_sd;
    mute = 1'b1;
    wait_log("to", 1, 1000);
    c0 = (log_q.size() > 0) ? log_q[0].c : cyc;
    while (cyc < c0 + 8) step();
    check_eq("to_err_early", error, 0);
    step();
    check_eq("to_err_set", error, 1);
    check_eq("to_busy_drop", busy, 0);
    mute = 1'b0;
    wait_sweep_done("to", 1000);
    exp_q.delete();
    push_txn(1'b0, 8'h21, 8'h00);
    push_sweep();
    check_seq("to");
    check_shadows("to");
    check_eq("to_err_sticky", error, 1);
    step();
    check_eq("to_done_pulses", n_sd - sd0, 1);

    // Asynchronous reset in WAIT_DONE restarts the init sequence
    n = 0;
    while (!(flag_work_s === 1'b1 && busy === 1'b1) && n < 1000) begin step(); n++; end
    check_eq("rst2_engine_busy", flag_work_s & busy, 1);
    step();
    step();
    reset = 1'b0;
    #1;
    check_all_zero("rst2");
    repeat (3) step();
    log_q.delete();
    reset = 1'b1;
    wait_init("reinit", 500);
    exp_q.delete();
    push_txn(1'b1, 8'h02, 8'h10);
    push_txn(1'b1, 8'h02, 8'h00);
    check_seq("reinit");
    check_eq("reinit_error", error, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_scheduler.md
Name: rtc_scheduler

Overview:
- Transaction scheduler that sits in front of the RTC bus read/write engine (the block driving a_d/cs/rd/wr and the multiplexed add_data_rtc bus).
- After reset it runs a fixed init write sequence, then periodically sweeps the six time/date registers into shadow registers.
- It inserts user write requests between sweep transactions and issues exactly one engine transaction at a time.

Parameters:
- REFRESH_CYCLES, 10_000_000: clk cycles between sweep requests (0.1 s at 100 MHz).
- START_TIMEOUT, 8: cycles allowed from the flag_in pulse to flag_work_s rising before an error is declared.
- CNT_W, 24: width of the refresh counter; must satisfy 2^CNT_W > REFRESH_CYCLES.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- wr_req  in  1  user write request; level, held until wr_ack.
- wr_addr  in  8  RTC register address for the user write.
- wr_data  in  8  data for the user write.
- wr_ack  out  1  one-cycle pulse when the user write transaction completes.
- flag_in  out  1  one-cycle start pulse to the engine.
- lee_escribe_m  out  1  to engine: 0 = read, 1 = write; held stable for the whole transaction.
- add  out  8  to engine: register address; held stable for the whole transaction.
- datos  out  8  to engine: write data; held stable for the whole transaction.
- flag_work_s  in  1  engine busy.
- tomar_dato  in  1  engine data-valid strobe.
- data  in  8  engine read data; valid in the cycle tomar_dato = 1.
- seg, min, hora, dia, mes, anio  out  8 each  shadow copies of the time/date registers.
- sweep_done  out  1  one-cycle pulse after all six reads of a sweep complete.
- init_done  out  1  level; set once the init sequence finishes.
- busy  out  1  high while any transaction is in flight.
- error  out  1  sticky; set on start timeout, cleared only by reset.

Behaviour:
- Reset (reset = 0, asynchronous): state = INIT_ISSUE, all outputs 0, refresh counter 0, sweep index 0, no pending flags.
- Init sequence: write 8'h02 <- 8'h10, then write 8'h02 <- 8'h00. init_done rises one cycle after the second write completes. User writes and sweeps are blocked until then, but a wr_req stays pending.
- Refresh counter: runs only while init_done = 1. When it reaches REFRESH_CYCLES-1 it wraps to 0 and sets sweep_pend. If a sweep is already pending or active, the tick is dropped (no queuing).
- Sweep order: index 0..5 reads addresses 8'h21, 22, 23, 24, 25, 26 into seg, min, hora, dia, mes, anio respectively.
- FSM states: INIT_ISSUE, IDLE, ISSUE, WAIT_START, WAIT_DONE, COMPLETE.
  - IDLE: the next transaction is chosen at this transaction boundary only.
    - Priority 1: wr_req pending, so issue the user write.
    - Priority 2: a sweep is active or pending, so issue a read of the current sweep index.
    - Otherwise stay in IDLE.
  - ISSUE: latch lee_escribe_m/add/datos (these were already valid in the previous cycle); flag_in = 1 for exactly this one cycle; busy = 1. Go to WAIT_START.
  - WAIT_START: wait for flag_work_s = 1, then go to WAIT_DONE. If the timeout counter reaches START_TIMEOUT: set error, drop the transaction, return to IDLE. A dropped sweep read aborts the sweep (index reset to 0, sweep_done not asserted). A dropped user write gives no wr_ack; the request stays pending and is retried.
  - WAIT_DONE: on tomar_dato = 1 during a read, capture data into the shadow register for the current index in that cycle. Go to COMPLETE on the flag_work_s falling edge (1 to 0).
  - COMPLETE: busy = 0.
    - User write: wr_ack = 1 for one cycle.
    - Sweep read: increment index. After index 5, wrap to 0, clear the active sweep and pulse sweep_done.
    - Go to IDLE.
- A user write inserted mid-sweep does not restart the sweep; the sweep resumes at the saved index.
- A wr_req arriving in the same cycle as a refresh tick: the write goes first and the tick is kept as sweep_pend.
- wr_req deasserted before acceptance is ignored. wr_addr/wr_data are sampled in IDLE at acceptance.
- Minimum gap of 1 IDLE cycle between transactions (engine returns to espera).
- Reset mid-transaction: the scheduler restarts the init sequence. The engine shares the same reset, so no cleanup is needed.

Decomposition:
- Package rtc_pkg holds:
  - state enum;
  - RTC address constants (ADDR_SEG..ADDR_ANIO = 8'h21..8'h26, ADDR_CMD_INIT = 8'h02);
  - init data constants 8'h10 / 8'h00;
  - OP_READ = 0, OP_WRITE = 1.
- One natural sub-module: rtc_refresh_timer (refresh counter plus tick generation, enabled by init_done).

Test Plan:
- Reset release, behavioural engine model (flag_work_s rises 2 cycles after flag_in, lasts 30 cycles) -> two writes to 8'h02 with datos 8'h10 then 8'h00, lee_escribe_m = 1; init_done = 1 after the second.
- REFRESH_CYCLES = 200, model returns 8'h45, 8'h30, 8'h12, 8'h07, 8'h04, 8'h17 -> seg = 45, min = 30, hora = 12, dia = 07, mes = 04, anio = 17; one sweep_done pulse; reads in address order 21..26.
- wr_req (addr 8'h23, data 8'h09) raised during the read of 8'h22 -> the write is issued right after the 8'h22 read; wr_ack pulses once; the sweep resumes at 8'h23 (read).
- Refresh tick in the same cycle as wr_req -> the write is issued first, then the sweep starts; no tick lost.
- Model never raises flag_work_s -> after 8 cycles error = 1; the sweep aborts; the next tick starts a new sweep at index 0.
- reset = 0 asserted in WAIT_DONE -> all outputs 0 immediately; after release the init sequence repeats.
